// File: rtl/mc_pkg.sv
// Shared encodings for the RV32I multicycle controller: FSM states, ALU
// operation codes, datapath mux selects and the opcodes the FSM decodes.
package mc_pkg;

    // Code 0 is kept free for a future debug-halt entry state.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECR    = 4'd7,
        S_EXECI    = 4'd8,
        S_ALUWB    = 4'd9,
        S_BRANCH   = 4'd10,
        S_JAL      = 4'd11,
        S_JALR     = 4'd12,
        S_LINK     = 4'd13,
        S_LUI      = 4'd14,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0101;
    localparam logic [3:0] ALU_SLL = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    function automatic logic [2:0] imm_src(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            OP_LUI:    return IMM_U;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// Maps the FSM's coarse ALU request plus funct fields onto a concrete ALU op.
module mc_alu_decoder
    import mc_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_op5,
    output logic [3:0] o_alu_control
);

    always_comb begin
        o_alu_control = ALU_ADD;
        case (i_alu_op)
            ALUOP_SUB: o_alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    // op[5] separates R-type sub from addi, whose bit 30 is immediate data.
                    3'b000:  o_alu_control = (i_op5 && i_funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  o_alu_control = ALU_SLL;
                    3'b010:  o_alu_control = ALU_SLT;
                    3'b100:  o_alu_control = ALU_XOR;
                    3'b101:  o_alu_control = i_funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  o_alu_control = ALU_OR;
                    3'b111:  o_alu_control = ALU_AND;
                    default: o_alu_control = ALU_ADD;
                endcase
            end
            default: o_alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RV32I control FSM sharing one ALU and one memory port; Moore
// state register with outputs qualified by op/funct3/Zero/Lt/MemReady.
module mc_controller
    import mc_pkg::*;
#(
    parameter int unsigned RESET_STATE_FETCH = 1
)
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       Lt,
    input  logic       MemReady,
    output logic       MemReq,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [3:0] ALUControl,
    output logic       IllegalInstr
);

    localparam state_t RESET_STATE = state_t'(4'(RESET_STATE_FETCH));

    state_t     r_state;
    state_t     w_next;
    logic       r_illegal;
    logic       w_mem_req, w_mem_write, w_adr_src, w_ir_write, w_pc_write, w_reg_write;
    logic [1:0] w_result_src, w_src_a, w_src_b, w_alu_op;
    logic [3:0] w_alu_control;
    logic       w_taken, w_branch_legal;

    always_comb begin
        w_taken        = 1'b0;
        w_branch_legal = 1'b1;
        case (funct3)
            3'b000:  w_taken = Zero;
            3'b001:  w_taken = !Zero;
            3'b100:  w_taken = Lt;
            3'b101:  w_taken = !Lt;
            default: w_branch_legal = 1'b0;
        endcase
    end

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        w_next       = r_state;
        w_mem_req    = 1'b0;
        w_mem_write  = 1'b0;
        w_adr_src    = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_result_src = RES_ALUOUT;
        w_src_a      = SRCA_PC;
        w_src_b      = SRCB_RS2;
        w_alu_op     = ALUOP_ADD;
        case (r_state)
            S_FETCH: begin
                w_mem_req    = 1'b1;
                w_src_b      = SRCB_FOUR;
                w_result_src = RES_ALURESULT;
                w_ir_write   = MemReady;
                w_pc_write   = MemReady;
                if (MemReady) w_next = S_DECODE;
            end
            S_DECODE: begin
                w_src_a = SRCA_OLDPC;
                w_src_b = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_RTYPE:          w_next = S_EXECR;
                    OP_ITYPE:          w_next = S_EXECI;
                    OP_BRANCH:         w_next = S_BRANCH;
                    OP_JAL:            w_next = S_JAL;
                    OP_JALR:           w_next = S_JALR;
                    OP_LUI:            w_next = S_LUI;
                    default:           w_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                w_src_a = SRCA_RS1;
                w_src_b = SRCB_IMM;
                w_next  = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_mem_req = 1'b1;
                w_adr_src = 1'b1;
                if (MemReady) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                w_result_src = RES_DATA;
                w_reg_write  = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEMWRITE: begin
                w_mem_req   = 1'b1;
                w_mem_write = 1'b1;
                w_adr_src   = 1'b1;
                if (MemReady) w_next = S_FETCH;
            end
            S_EXECR: begin
                w_src_a  = SRCA_RS1;
                w_alu_op = ALUOP_FUNCT;
                w_next   = S_ALUWB;
            end
            S_EXECI: begin
                w_src_a  = SRCA_RS1;
                w_src_b  = SRCB_IMM;
                w_alu_op = ALUOP_FUNCT;
                w_next   = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                w_src_a    = SRCA_RS1;
                w_alu_op   = ALUOP_SUB;
                w_pc_write = w_branch_legal && w_taken;
                w_next     = w_branch_legal ? S_FETCH : S_TRAP;
            end
            S_JAL: begin
                w_pc_write = 1'b1;
                w_src_a    = SRCA_OLDPC;
                w_src_b    = SRCB_FOUR;
                w_next     = S_ALUWB;
            end
            S_JALR: begin
                w_src_a      = SRCA_RS1;
                w_src_b      = SRCB_IMM;
                w_result_src = RES_ALURESULT;
                w_pc_write   = 1'b1;
                w_next       = S_LINK;
            end
            S_LINK: begin
                w_src_a = SRCA_OLDPC;
                w_src_b = SRCB_FOUR;
                w_next  = S_ALUWB;
            end
            S_LUI: begin
                w_src_a = SRCA_ZERO;
                w_src_b = SRCB_IMM;
                w_next  = S_ALUWB;
            end
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_TRAP;
        endcase
    end

    mc_alu_decoder u_alu_decoder (
        .i_alu_op      (w_alu_op),
        .i_funct3      (funct3),
        .i_funct7b5    (funct7b5),
        .i_op5         (op[5]),
        .o_alu_control (w_alu_control)
    );

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= RESET_STATE;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_illegal <= r_illegal | (w_next == S_TRAP);
        end
    end

    // The state register alone cannot silence S_FETCH during reset, so gate outputs directly.
    assign MemReq       = reset_n & w_mem_req;
    assign MemWrite     = reset_n & w_mem_write;
    assign AdrSrc       = reset_n & w_adr_src;
    assign IRWrite      = reset_n & w_ir_write;
    assign PCWrite      = reset_n & w_pc_write;
    assign RegWrite     = reset_n & w_reg_write;
    assign ResultSrc    = reset_n ? w_result_src  : 2'b00;
    assign ALUSrcA      = reset_n ? w_src_a       : 2'b00;
    assign ALUSrcB      = reset_n ? w_src_b       : 2'b00;
    assign ImmSrc       = reset_n ? imm_src(op)   : 3'b000;
    assign ALUControl   = reset_n ? w_alu_control : 4'b0000;
    assign IllegalInstr = r_illegal;

endmodule
